// File: rtl/mem_access_master_pkg.sv
// Shared widths, FSM encoding and timeout default for the burst memory master.
package mem_access_master_pkg;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;
endpackage

// File: rtl/mem_access_master_if.sv
// Single-word request/completion bus between the burst master and a word memory.
interface mem_access_master_if;
    import mem_access_master_pkg::*;

    logic              m_valid;
    logic              m_WR;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_out;
    logic [DATA_W-1:0] m_data_in;
    logic              m_ready;

    modport master (output m_valid, m_WR, m_addr, m_data_out, input m_data_in, m_ready);
    modport slave  (input m_valid, m_WR, m_addr, m_data_out, output m_data_in, m_ready);
endinterface

// File: rtl/mem_access_master.sv
// Burst read/write master: issues length words from base_addr, one per completion,
// with an incrementing write pattern and a per-word completion timeout.
module mem_access_master
    import mem_access_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    mem_access_master_if.master m
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] remain;
    logic [TW-1:0]     tcnt;
    logic              accept, xfer, last, tmo;

    assign accept = (state == S_IDLE) && start;
    assign xfer   = (state == S_REQ) && m.m_ready;
    assign last   = (remain == ADDR_W'(1));
    // tcnt holds the number of stalled cycles already spent on this word
    assign tmo    = (state == S_REQ) && !m.m_ready && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (length != '0) ? S_REQ : S_DONE;
            S_REQ: begin
                if (xfer && last) state_nxt = S_DONE;
                else if (tmo)     state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            remain   <= '0;
            tcnt     <= '0;
            error    <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                wr_q   <= cmd_wr;
                addr_q <= base_addr;
                data_q <= seed;
                remain <= length;
                tcnt   <= '0;
                error  <= 1'b0;
            end else if (xfer) begin
                // address wraps naturally at the top of the 10-bit space
                addr_q <= addr_q + ADDR_W'(1);
                data_q <= data_q + DATA_W'(1);
                remain <= remain - ADDR_W'(1);
                tcnt   <= '0;
                if (!wr_q) begin
                    rd_data  <= m.m_data_in;
                    rd_valid <= 1'b1;
                end
            end else if (state == S_REQ) begin
                tcnt <= tcnt + TW'(1);
            end
            if (tmo) error <= 1'b1;
        end
    end

    assign busy         = (state == S_REQ);
    assign done         = (state == S_DONE);
    assign m.m_valid    = (state == S_REQ);
    assign m.m_WR       = wr_q;
    assign m.m_addr     = addr_q;
    assign m.m_data_out = data_q;
endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench: word-level behavioural model + scoreboard logs, with literal pins per scenario.
module tb_mem_access_master;
    import mem_access_master_pkg::*;

    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              cmd_wr = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy, done, error, rd_valid;
    logic [DATA_W-1:0] rd_data;

    mem_access_master_if m ();

    mem_access_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_wr(cmd_wr),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .rd_valid(rd_valid), .m(m)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [15:0] smem [1024];
    int  lat = 0;
    bit  hold_low = 0, force_rdy = 0;
    int  wcnt = 0;
    logic pv, hs;

    assign m.m_data_in = smem[m.m_addr];

    always @(posedge clk) begin
        hs = m.m_valid && m.m_ready;
        pv = m.m_valid;
        if (hs && m.m_WR) smem[m.m_addr] = m.m_data_out;
        #1;
        if (hs || !pv) wcnt = 0;
        else           wcnt++;
        m.m_ready = force_rdy || (m.m_valid && !hold_low && wcnt >= lat);
    end

    // ---------------- behavioural model + logs ----------------
    logic [15:0] mmem [1024];
    bit   act = 0, dn = 0, en = 0, rdn = 0, errf = 0, mwr = 0, idle;
    int   mbase, mseed, idx, left, wt, a;
    logic [15:0] rexp;

    int   wl_a[$], wl_d[$], rl[$];
    int   dcnt, bcnt, vcnt;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
            chk("rst_error", error, 0);     chk("rst_rd_valid", rd_valid, 0);
            chk("rst_m_valid", m.m_valid, 0); chk("rst_m_WR", m.m_WR, 0);
            chk("rst_rd_data", rd_data, 0); chk("rst_m_addr", m.m_addr, 0);
            chk("rst_m_data_out", m.m_data_out, 0);
            act = 0; dn = 0; en = 0; rdn = 0; errf = 0;
        end else begin
            chk("m_valid", m.m_valid, act);
            chk("busy", busy, act);
            chk("done", done, dn);
            chk("error", error, errf);
            chk("rd_valid", rd_valid, rdn);
            if (rdn) chk("rd_data", rd_data, rexp);
            if (act) begin
                chk("m_addr", m.m_addr, (mbase + idx) % 1024);
                chk("m_WR", m.m_WR, mwr);
                if (mwr) chk("m_data_out", m.m_data_out, (mseed + idx) & 'hFFFF);
            end
            if (m.m_valid && m.m_ready && m.m_WR) begin
                wl_a.push_back(int'(m.m_addr));
                wl_d.push_back(int'(m.m_data_out));
            end
            if (rd_valid) rl.push_back(int'(rd_data));
            if (done) dcnt++;
            if (busy) bcnt++;
            if (m.m_valid) vcnt++;

            // advance to what the next cycle must show
            idle = !act && !dn && !en;
            dn = 0; en = 0; rdn = 0;
            if (act) begin
                if (m.m_ready) begin
                    a = (mbase + idx) % 1024;
                    if (mwr) mmem[a] = 16'((mseed + idx) & 'hFFFF);
                    else begin rdn = 1; rexp = mmem[a]; end
                    idx++; left--; wt = 0;
                    if (left == 0) begin act = 0; dn = 1; end
                end else begin
                    wt++;
                    if (wt == TMO) begin act = 0; en = 1; errf = 1; end
                end
            end else if (idle && start) begin
                errf = 0;
                if (length != 0) begin
                    act = 1; mwr = cmd_wr; mbase = int'(base_addr); mseed = int'(seed);
                    idx = 0; left = int'(length); wt = 0;
                end else dn = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_logs();
        wl_a.delete(); wl_d.delete(); rl.delete();
        dcnt = 0; bcnt = 0; vcnt = 0;
    endtask

    task automatic pulse_start(input bit wr, input int base, input int len, input int sd);
        @(posedge clk); #1;
        start = 1; cmd_wr = wr; base_addr = 10'(base); length = 10'(len); seed = 16'(sd);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_end(input int max_cyc);
        bit seen = 0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            seen = done || error;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL burst_end: no done/error within %0d cycles", max_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic burst(input bit wr, input int base, input int len, input int sd, input int max_cyc);
        clear_logs();
        pulse_start(wr, base, len, sd);
        wait_end(max_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #3 reset = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_m_valid", m.m_valid, 0);

        // write burst, memory ready every cycle
        lat = 0;
        burst(1, 5, 4, 'h1000, 50);
        for (int i = 0; i < 4; i++) begin
            chk("w1_addr", wl_a[i], 5 + i);
            chk("w1_data", wl_d[i], 'h1000 + i);
        end
        chk("w1_words", wl_a.size(), 4);
        chk("w1_done_cnt", dcnt, 1);

        // read back with two stall cycles per word
        lat = 2;
        burst(0, 5, 4, 0, 80);
        chk("r1_count", rl.size(), 4);
        for (int i = 0; i < 4; i++) chk("r1_data", rl[i], 'h1000 + i);
        chk("r1_valid_cycles", vcnt, 12);
        chk("r1_done_cnt", dcnt, 1);

        // address wrap and data wrap
        lat = 0;
        burst(1, 1022, 3, 'hFFFF, 50);
        chk("w2_addr0", wl_a[0], 1022); chk("w2_addr1", wl_a[1], 1023); chk("w2_addr2", wl_a[2], 0);
        chk("w2_data0", wl_d[0], 'hFFFF); chk("w2_data1", wl_d[1], 0); chk("w2_data2", wl_d[2], 1);

        // start while busy is ignored
        lat = 1;
        clear_logs();
        pulse_start(1, 200, 3, 'h2222);
        pulse_start(0, 0, 0, 0);
        wait_end(50);
        chk("busy_start_words", wl_a.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("busy_start_addr", wl_a[i], 200 + i);
            chk("busy_start_data", wl_d[i], 'h2222 + i);
        end
        chk("busy_start_done_cnt", dcnt, 1);

        // zero-length command
        lat = 0;
        burst(0, 7, 0, 0, 10);
        chk("len0_done_cnt", dcnt, 1);
        chk("len0_busy_cycles", bcnt, 0);
        chk("len0_valid_cycles", vcnt, 0);

        // stray m_ready while idle
        clear_logs();
        force_rdy = 1;
        repeat (4) @(posedge clk);
        force_rdy = 0;
        @(negedge clk);
        chk("stray_done_cnt", dcnt, 0);
        chk("stray_rd_cnt", rl.size(), 0);
        chk("stray_error", error, 0);

        // timeout
        hold_low = 1;
        burst(1, 100, 2, 'h3333, 60);
        hold_low = 0;
        chk("tmo_valid_cycles", vcnt, 16);
        chk("tmo_done_cnt", dcnt, 0);
        chk("tmo_words", wl_a.size(), 0);
        repeat (3) @(negedge clk);
        chk("tmo_error_sticky", error, 1);
        clear_logs();
        pulse_start(0, 5, 1, 0);
        @(negedge clk);
        chk("tmo_error_cleared", error, 0);
        wait_end(20);
        chk("tmo_next_rd", rl[0], 'h1000);

        // reset during second word of a 4-word write
        lat = 0;
        clear_logs();
        pulse_start(1, 300, 4, 'h4000);
        @(posedge clk); #3;
        reset = 1;
        #1;
        chk("arst_m_valid", m.m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_m_addr", m.m_addr, 0);
        chk("arst_m_data_out", m.m_data_out, 0);
        chk("arst_m_WR", m.m_WR, 0);
        chk("arst_words", wl_a.size(), 1);
        repeat (2) @(posedge clk);
        #3 reset = 0;
        repeat (3) @(negedge clk);
        chk("arst_done_cnt", dcnt, 0);
        chk("arst_idle_valid", m.m_valid, 0);
        burst(1, 300, 4, 'h5000, 50);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_addr", wl_a[i], 300 + i);
            chk("post_rst_data", wl_d[i], 'h5000 + i);
        end
        chk("post_rst_done_cnt", dcnt, 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
